// File: rtl/irrigation_countdown.sv
// Irrigation countdown: MM:SS BCD timer reloaded from a mode-selected preset,
// ticking down once per TICK_DIVISOR clocks and pulsing expired at 00:00.
module irrigation_countdown #(
   parameter int TICK_DIVISOR = 50_000_000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        timer_reset,
   input  logic        splinker_mode_on,
   input  logic [12:0] spk_preset,
   input  logic [12:0] drip_preset,
   output logic [1:0]  minutes_d,
   output logic [3:0]  minutes_u,
   output logic [2:0]  seconds_d,
   output logic [3:0]  seconds_u,
   output logic        running,
   output logic        expired,
   output logic        preset_invalid
);

   localparam int PW = $clog2(TICK_DIVISOR);
   localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIVISOR - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [1:0] md;
      logic [3:0] mu;
      logic [2:0] sd;
      logic [3:0] su;
   } bcd_time_t;

   state_t    state_q, state_d;
   bcd_time_t digits_q, digits_d;
   logic [PW-1:0] presc_q, presc_d;
   logic      running_q, running_d;
   logic      expired_q, expired_d;
   logic      invalid_q, invalid_d;

   bcd_time_t sel;
   bcd_time_t dec;
   logic      sel_bad;
   logic      tick;

   // Only called in RUN, where digits are legal and nonzero.
   function automatic bcd_time_t bcd_dec(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.su != 4'd0) begin
         r.su = t.su - 4'd1;
      end else begin
         r.su = 4'd9;
         if (t.sd != 3'd0) begin
            r.sd = t.sd - 3'd1;
         end else begin
            r.sd = 3'd5;
            if (t.mu != 4'd0) begin
               r.mu = t.mu - 4'd1;
            end else begin
               r.mu = 4'd9;
               r.md = t.md - 2'd1;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      sel       = splinker_mode_on ? bcd_time_t'(spk_preset)
                                   : bcd_time_t'(drip_preset);
      sel_bad   = (sel.mu > 4'd9) || (sel.sd > 3'd5) || (sel.su > 4'd9);
      dec       = bcd_dec(digits_q);
      tick      = (presc_q == TICK_MAX);

      state_d   = state_q;
      digits_d  = digits_q;
      presc_d   = presc_q;
      expired_d = 1'b0;
      invalid_d = invalid_q;

      if (timer_reset) begin
         state_d   = S_LOAD;
         digits_d  = sel_bad ? '0 : sel;
         presc_d   = '0;
         invalid_d = sel_bad;
      end else begin
         unique case (state_q)
            S_LOAD: begin
               presc_d = '0;
               if (digits_q == '0) begin
                  state_d   = S_DONE;
                  expired_d = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (tick) begin
                  presc_d  = '0;
                  digits_d = dec;
                  if (dec == '0) begin
                     state_d   = S_DONE;
                     expired_d = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            S_DONE: begin
               digits_d = '0;
               presc_d  = '0;
            end
            default: begin
               state_d  = S_LOAD;
               digits_d = '0;
               presc_d  = '0;
            end
         endcase
      end

      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_LOAD;
         digits_q  <= '0;
         presc_q   <= '0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         digits_q  <= digits_d;
         presc_q   <= presc_d;
         running_q <= running_d;
         expired_q <= expired_d;
         invalid_q <= invalid_d;
      end
   end

   assign minutes_d      = digits_q.md;
   assign minutes_u      = digits_q.mu;
   assign seconds_d      = digits_q.sd;
   assign seconds_u      = digits_q.su;
   assign running        = running_q;
   assign expired        = expired_q;
   assign preset_invalid = invalid_q;

endmodule

// File: tb/tb_irrigation_countdown.sv
// Directed bench for irrigation_countdown with a 4-cycle tick.
module tb_irrigation_countdown;

   localparam int TD = 4;

   logic        clock;
   logic        reset_n;
   logic        timer_reset;
   logic        splinker_mode_on;
   logic [12:0] spk_preset;
   logic [12:0] drip_preset;
   logic [1:0]  minutes_d;
   logic [3:0]  minutes_u;
   logic [2:0]  seconds_d;
   logic [3:0]  seconds_u;
   logic        running;
   logic        expired;
   logic        preset_invalid;
   logic [12:0] dig;

   int checks = 0;
   int errors = 0;

   irrigation_countdown #(.TICK_DIVISOR(TD)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .timer_reset      (timer_reset),
      .splinker_mode_on (splinker_mode_on),
      .spk_preset       (spk_preset),
      .drip_preset      (drip_preset),
      .minutes_d        (minutes_d),
      .minutes_u        (minutes_u),
      .seconds_d        (seconds_d),
      .seconds_u        (seconds_u),
      .running          (running),
      .expired          (expired),
      .preset_invalid   (preset_invalid)
   );

   assign dig = {minutes_d, minutes_u, seconds_d, seconds_u};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Seconds -> packed {md, mu, sd, su}
   function automatic logic [12:0] bcd(input int s);
      int m;
      int r;
      m = s / 60;
      r = s % 60;
      return {2'(m / 10), 4'(m % 10), 3'(r / 10), 4'(r % 10)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // One reload edge, then the release edge.
   task automatic load_rel();
      timer_reset = 1'b1;
      cyc(1);
      timer_reset = 1'b0;
      cyc(1);
   endtask

   initial begin
      reset_n          = 1'b0;
      timer_reset      = 1'b1;
      splinker_mode_on = 1'b1;
      spk_preset       = bcd(3);
      drip_preset      = '0;
      #2;
      chk("rst_dig", 32'(dig), 32'd0);
      chk("rst_run", 32'(running), 32'd0);
      chk("rst_exp", 32'(expired), 32'd0);
      chk("rst_inv", 32'(preset_invalid), 32'd0);
      @(posedge clock);
      #3 reset_n = 1'b1;

      // basic count 00:03
      cyc(1);
      chk("bas_load", 32'(dig), 32'(bcd(3)));
      chk("bas_load_run", 32'(running), 32'd0);
      cyc(1);
      timer_reset = 1'b0;
      cyc(1);
      chk("bas_run", 32'(running), 32'd1);
      chk("bas_rel", 32'(dig), 32'(bcd(3)));
      cyc(3);
      chk("bas_pre", 32'(dig), 32'(bcd(3)));
      cyc(1);
      chk("bas_t1", 32'(dig), 32'(bcd(2)));
      cyc(4);
      chk("bas_t2", 32'(dig), 32'(bcd(1)));
      cyc(4);
      chk("bas_t3", 32'(dig), 32'd0);
      chk("bas_run0", 32'(running), 32'd0);
      chk("bas_exp", 32'(expired), 32'd1);
      cyc(1);
      chk("bas_exp1", 32'(expired), 32'd0);
      cyc(4);
      chk("bas_hold", 32'(dig), 32'd0);
      chk("bas_hexp", 32'(expired), 32'd0);

      // invalid drip preset 01:60
      splinker_mode_on = 1'b0;
      drip_preset      = {2'd0, 4'd1, 3'd6, 4'd0};
      timer_reset      = 1'b1;
      cyc(1);
      chk("inv_dig", 32'(dig), 32'd0);
      chk("inv_flag", 32'(preset_invalid), 32'd1);
      timer_reset = 1'b0;
      cyc(1);
      chk("inv_exp", 32'(expired), 32'd1);
      chk("inv_run", 32'(running), 32'd0);
      cyc(1);
      chk("inv_exp1", 32'(expired), 32'd0);

      // borrow chains
      splinker_mode_on = 1'b1;
      spk_preset       = bcd(600);
      load_rel();
      chk("inv_clr", 32'(preset_invalid), 32'd0);
      cyc(4);
      chk("brw_1000", 32'(dig), 32'(bcd(599)));
      spk_preset = bcd(60);
      load_rel();
      cyc(4);
      chk("brw_0100", 32'(dig), 32'(bcd(59)));
      spk_preset = bcd(10);
      load_rel();
      cyc(4);
      chk("brw_0010", 32'(dig), 32'(bcd(9)));

      // reload coincident with a tick edge
      spk_preset = bcd(317);
      load_rel();
      spk_preset = bcd(125);
      cyc(3);
      chk("rl_pre", 32'(dig), 32'(bcd(317)));
      timer_reset = 1'b1;
      cyc(1);
      chk("rl_win", 32'(dig), 32'(bcd(125)));
      chk("rl_run0", 32'(running), 32'd0);
      timer_reset = 1'b0;
      cyc(1);
      chk("rl_run1", 32'(running), 32'd1);
      cyc(3);
      chk("rl_hold", 32'(dig), 32'(bcd(125)));
      cyc(1);
      chk("rl_tick", 32'(dig), 32'(bcd(124)));

      // async reset mid-cycle
      spk_preset = bcd(150);
      load_rel();
      cyc(2);
      chk("ar_pre", 32'(dig), 32'(bcd(150)));
      #3 reset_n = 1'b0;
      #1;
      chk("ar_dig", 32'(dig), 32'd0);
      chk("ar_run", 32'(running), 32'd0);
      #1 reset_n = 1'b1;
      cyc(1);
      chk("ar_exp", 32'(expired), 32'd1);
      chk("ar_state", 32'(running), 32'd0);

      // mode switch during RUN
      drip_preset = bcd(45);
      load_rel();
      cyc(2);
      splinker_mode_on = 1'b0;
      cyc(2);
      chk("ms_tick", 32'(dig), 32'(bcd(149)));
      chk("ms_run", 32'(running), 32'd1);
      timer_reset = 1'b1;
      cyc(1);
      chk("ms_drip", 32'(dig), 32'(bcd(45)));
      timer_reset = 1'b0;

      // maximum 39:59 full run
      splinker_mode_on = 1'b1;
      spk_preset       = bcd(2399);
      load_rel();
      chk("max_start", 32'(dig), 32'(bcd(2399)));
      for (int i = 1; i <= 2399; i++) begin
         cyc(TD);
         chk("max", 32'(dig), 32'(bcd(2399 - i)));
      end
      chk("max_exp", 32'(expired), 32'd1);
      cyc(1);
      chk("max_exp1", 32'(expired), 32'd0);
      chk("max_hold", 32'(dig), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
